// File: rtl/heart_model_if.sv
// Signal bundle between the pacemaker (master) and the cardiac plant (slave).
interface heart_model_if;
  logic       pa;
  logic       pv;
  logic       av_block;
  logic       sa;
  logic       sv;
  logic [1:0] v_state;
  logic [7:0] beat_cnt;

  modport master (output pa, pv, av_block, input sa, sv, v_state, beat_cnt);
  modport slave  (input pa, pv, av_block, output sa, sv, v_state, beat_cnt);
endinterface

// File: rtl/heart_model.sv
// Behavioural cardiac plant: sinus rhythm, AV conduction, ventricular
// refractory period, escape rhythm and AV block, driven by pace pulses.
module heart_model #(
  parameter int A_INT  = 100,
  parameter int AV_DLY = 40,
  parameter int VRP    = 30,
  parameter int V_ESC  = 150,
  parameter int PW     = 2,
  parameter int CW     = 16
) (
  input logic          clk,
  input logic          rst,
  heart_model_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COND = 2'd1,
    REFR = 2'd2
  } v_state_t;

  localparam logic [CW-1:0] A_TC   = CW'(A_INT - 1);
  localparam logic [CW-1:0] AV_TC  = CW'(AV_DLY - 1);
  localparam logic [CW-1:0] VRP_TC = CW'(VRP - 1);
  localparam logic [CW-1:0] E_TC   = CW'(V_ESC - 1);
  localparam logic [CW-1:0] P_LOAD = CW'(PW - 1);

  logic          pa_d, pv_d;
  logic          pa_e, pv_e;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] v_cnt, v_cnt_n;
  logic [CW-1:0] e_cnt;
  logic [CW-1:0] sa_cnt, sv_cnt;
  logic          sa_q, sv_q;
  logic [7:0]    beat;
  v_state_t      state, state_n;
  logic          a_tc, a_event, a_intr, esc_tc;
  logic          v_pace, v_intr, v_event;

  assign pa_e    = bus.pa & ~pa_d;
  assign pv_e    = bus.pv & ~pv_d;
  assign a_tc    = (a_cnt == A_TC);
  // A pace on the terminal-count cycle makes the event paced, so no sense.
  assign a_event = pa_e | a_tc;
  assign a_intr  = a_tc & ~pa_e;
  assign esc_tc  = (e_cnt == E_TC);
  assign v_event = v_pace | v_intr;

  assign bus.sa       = sa_q;
  assign bus.sv       = sv_q;
  assign bus.v_state  = state;
  assign bus.beat_cnt = beat;

  // Registered copies of the pace inputs for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      pa_d <= 1'b0;
      pv_d <= 1'b0;
    end else begin
      pa_d <= bus.pa;
      pv_d <= bus.pv;
    end
  end

  // Sinus node: free-running interval counter, restarted by any atrial event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         a_cnt <= '0;
    else if (a_event) a_cnt <= '0;
    else              a_cnt <= a_cnt + CW'(1);
  end

  // Ventricular FSM: next state, conduction timer and event decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_n = state;
    v_cnt_n = v_cnt;
    v_pace  = 1'b0;
    v_intr  = 1'b0;
    case (state)
      IDLE: begin
        if (pv_e)        v_pace = 1'b1;
        else if (esc_tc) v_intr = 1'b1;
        else if (a_event && !bus.av_block) begin
          state_n = COND;
          v_cnt_n = '0;
        end
      end
      COND: begin
        // Atrial events and av_block are ignored once conduction is in flight.
        v_cnt_n = v_cnt + CW'(1);
        if (pv_e)                         v_pace = 1'b1;
        else if (esc_tc || v_cnt == AV_TC) v_intr = 1'b1;
      end
      REFR: begin
        if (v_cnt == VRP_TC) begin
          state_n = IDLE;
          v_cnt_n = '0;
        end else begin
          v_cnt_n = v_cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        v_cnt_n = '0;
      end
    endcase
    // Paced, conducted and escape beats all enter refractory with a fresh timer.
    if (v_pace || v_intr) begin
      state_n = REFR;
      v_cnt_n = '0;
    end
  end

  // Ventricular FSM state register and its shared interval timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      v_cnt <= '0;
    end else begin
      state <= state_n;
      v_cnt <= v_cnt_n;
    end
  end

  // Escape timer and beat counter, both keyed to ventricular events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_cnt <= '0;
      beat  <= '0;
    end else if (v_event) begin
      e_cnt <= '0;
      beat  <= beat + 8'd1;
    end else begin
      e_cnt <= e_cnt + CW'(1);
    end
  end

  // Atrial sense pulse: PW cycles wide, retriggered by a new intrinsic event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa_q   <= 1'b0;
      sa_cnt <= '0;
    end else if (a_intr) begin
      sa_q   <= 1'b1;
      sa_cnt <= P_LOAD;
    end else if (sa_cnt != '0) begin
      sa_cnt <= sa_cnt - CW'(1);
    end else begin
      sa_q <= 1'b0;
    end
  end

  // Ventricular sense pulse: same shape, fired only by intrinsic beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv_q   <= 1'b0;
      sv_cnt <= '0;
    end else if (v_intr) begin
      sv_q   <= 1'b1;
      sv_cnt <= P_LOAD;
    end else if (sv_cnt != '0) begin
      sv_cnt <= sv_cnt - CW'(1);
    end else begin
      sv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_heart_model.sv
// Directed bench for heart_model with default parameters. Edges are
// numbered from reset release (first rising edge = 1); sense pulse rise and
// fall edges are logged and compared against hand-derived edge numbers.
module tb_heart_model;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_no;
  int   sa_rise[$], sa_fall[$], sv_rise[$], sv_fall[$];
  logic sa_p, sv_p;
  logic saw_cond;

  heart_model_if hif ();

  heart_model dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  // Edge number since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_no <= 0;
    else      edge_no <= edge_no + 1;
  end

  // Pulse logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (hif.sa && !sa_p) sa_rise.push_back(edge_no);
      if (!hif.sa && sa_p) sa_fall.push_back(edge_no);
      if (hif.sv && !sv_p) sv_rise.push_back(edge_no);
      if (!hif.sv && sv_p) sv_fall.push_back(edge_no);
      if (hif.v_state == 2'd1) saw_cond = 1'b1;
      sa_p = hif.sa;
      sv_p = hif.sv;
    end else begin
      sa_p = 1'b0;
      sv_p = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, edge_no=%0d required completion", edge_no);
    $fatal(1);
  end

  task automatic clear_logs();
    sa_rise.delete(); sa_fall.delete(); sv_rise.delete(); sv_fall.delete();
    saw_cond = 1'b0;
  endtask

  task automatic do_reset(input logic blk);
    rst = 1'b0;
    hif.pa = 1'b0;
    hif.pv = 1'b0;
    hif.av_block = blk;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Return 1 time unit after rising edge n has happened.
  task automatic go_to(input int n);
    while (edge_no < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hif.pa = 1'b0; hif.pv = 1'b0; hif.av_block = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (hif.sa !== 1'b0) begin n_err++; $display("FAIL reset_sa: got %b want 0", hif.sa); end
    n_cmp++; if (hif.sv !== 1'b0) begin n_err++; $display("FAIL reset_sv: got %b want 0", hif.sv); end
    n_cmp++; if (hif.v_state !== 2'd0) begin n_err++; $display("FAIL reset_v_state: got %0d want 0", hif.v_state); end
    n_cmp++; if (hif.beat_cnt !== 8'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d want 0", hif.beat_cnt); end
  endtask

  task automatic test_free_run();
    int e_sa[$], e_sv[$], e_saf[$], e_svf[$];
    int got;
    do_reset(1'b0);
    go_to(100);
    n_cmp++; if (hif.v_state !== 2'd1) begin n_err++; $display("FAIL free_cond_100: got %0d want 1", hif.v_state); end
    go_to(140);
    n_cmp++; if (hif.v_state !== 2'd2) begin n_err++; $display("FAIL free_refr_140: got %0d want 2", hif.v_state); end
    go_to(169);
    n_cmp++; if (hif.v_state !== 2'd2) begin n_err++; $display("FAIL free_refr_169: got %0d want 2", hif.v_state); end
    go_to(170);
    n_cmp++; if (hif.v_state !== 2'd0) begin n_err++; $display("FAIL free_idle_170: got %0d want 0", hif.v_state); end
    go_to(345);
    e_sa = '{100, 200, 300}; e_saf = '{102, 202, 302};
    e_sv = '{140, 240, 340}; e_svf = '{142, 242, 342};
    n_cmp++; if (sa_rise.size() != 3) begin n_err++; $display("FAIL free_sa_count: got %0d want 3", sa_rise.size()); end
    n_cmp++; if (sv_rise.size() != 3) begin n_err++; $display("FAIL free_sv_count: got %0d want 3", sv_rise.size()); end
    foreach (e_sa[i]) begin
      got = (i < sa_rise.size()) ? sa_rise[i] : -1;
      n_cmp++; if (got != e_sa[i]) begin n_err++; $display("FAIL free_sa_rise[%0d]: got %0d want %0d", i, got, e_sa[i]); end
      got = (i < sa_fall.size()) ? sa_fall[i] : -1;
      n_cmp++; if (got != e_saf[i]) begin n_err++; $display("FAIL free_sa_fall[%0d]: got %0d want %0d", i, got, e_saf[i]); end
      got = (i < sv_rise.size()) ? sv_rise[i] : -1;
      n_cmp++; if (got != e_sv[i]) begin n_err++; $display("FAIL free_sv_rise[%0d]: got %0d want %0d", i, got, e_sv[i]); end
      got = (i < sv_fall.size()) ? sv_fall[i] : -1;
      n_cmp++; if (got != e_svf[i]) begin n_err++; $display("FAIL free_sv_fall[%0d]: got %0d want %0d", i, got, e_svf[i]); end
    end
    n_cmp++; if (hif.beat_cnt !== 8'd3) begin n_err++; $display("FAIL free_beat_cnt: got %0d want 3", hif.beat_cnt); end
  endtask

  task automatic test_av_block();
    int e_sa[$], e_sv[$];
    int got;
    do_reset(1'b1);
    go_to(455);
    e_sa = '{100, 200, 300, 400};
    e_sv = '{150, 300, 450};
    n_cmp++; if (sa_rise.size() != 4) begin n_err++; $display("FAIL avb_sa_count: got %0d want 4", sa_rise.size()); end
    n_cmp++; if (sv_rise.size() != 3) begin n_err++; $display("FAIL avb_sv_count: got %0d want 3", sv_rise.size()); end
    foreach (e_sa[i]) begin
      got = (i < sa_rise.size()) ? sa_rise[i] : -1;
      n_cmp++; if (got != e_sa[i]) begin n_err++; $display("FAIL avb_sa_rise[%0d]: got %0d want %0d", i, got, e_sa[i]); end
    end
    foreach (e_sv[i]) begin
      got = (i < sv_rise.size()) ? sv_rise[i] : -1;
      n_cmp++; if (got != e_sv[i]) begin n_err++; $display("FAIL avb_sv_rise[%0d]: got %0d want %0d", i, got, e_sv[i]); end
    end
    n_cmp++; if (saw_cond !== 1'b0) begin n_err++; $display("FAIL avb_no_cond: got %b want 0", saw_cond); end
    n_cmp++; if (hif.beat_cnt !== 8'd3) begin n_err++; $display("FAIL avb_beat_cnt: got %0d want 3", hif.beat_cnt); end
  endtask

  task automatic test_atrial_pace();
    int e_sa[$], e_sv[$];
    int got;
    do_reset(1'b0);
    go_to(49); hif.pa = 1'b1;
    go_to(50);
    n_cmp++; if (hif.sa !== 1'b0) begin n_err++; $display("FAIL apace_no_sa_50: got %b want 0", hif.sa); end
    n_cmp++; if (hif.v_state !== 2'd1) begin n_err++; $display("FAIL apace_cond_50: got %0d want 1", hif.v_state); end
    go_to(52); hif.pa = 1'b0;
    // Held pace: rises at edge 160 (during COND) and stays high for 70 cycles.
    go_to(159); hif.pa = 1'b1;
    go_to(230); hif.pa = 1'b0;
    go_to(305);
    e_sa = '{150, 260};
    e_sv = '{90, 190, 300};
    n_cmp++; if (sa_rise.size() != 2) begin n_err++; $display("FAIL apace_sa_count: got %0d want 2", sa_rise.size()); end
    n_cmp++; if (sv_rise.size() != 3) begin n_err++; $display("FAIL apace_sv_count: got %0d want 3", sv_rise.size()); end
    foreach (e_sa[i]) begin
      got = (i < sa_rise.size()) ? sa_rise[i] : -1;
      n_cmp++; if (got != e_sa[i]) begin n_err++; $display("FAIL apace_sa_rise[%0d]: got %0d want %0d", i, got, e_sa[i]); end
    end
    foreach (e_sv[i]) begin
      got = (i < sv_rise.size()) ? sv_rise[i] : -1;
      n_cmp++; if (got != e_sv[i]) begin n_err++; $display("FAIL apace_sv_rise[%0d]: got %0d want %0d", i, got, e_sv[i]); end
    end
    n_cmp++; if (hif.beat_cnt !== 8'd3) begin n_err++; $display("FAIL apace_beat_cnt: got %0d want 3", hif.beat_cnt); end
  endtask

  task automatic test_vent_pace();
    int e_sa[$];
    int got;
    do_reset(1'b0);
    go_to(119); hif.pv = 1'b1;
    go_to(120);
    n_cmp++; if (hif.v_state !== 2'd2) begin n_err++; $display("FAIL vpace_refr_120: got %0d want 2", hif.v_state); end
    n_cmp++; if (hif.beat_cnt !== 8'd1) begin n_err++; $display("FAIL vpace_beat_120: got %0d want 1", hif.beat_cnt); end
    n_cmp++; if (hif.sv !== 1'b0) begin n_err++; $display("FAIL vpace_no_sv_120: got %b want 0", hif.sv); end
    go_to(121); hif.pv = 1'b0;
    go_to(149);
    n_cmp++; if (hif.v_state !== 2'd2) begin n_err++; $display("FAIL vpace_refr_149: got %0d want 2", hif.v_state); end
    go_to(150);
    n_cmp++; if (hif.v_state !== 2'd0) begin n_err++; $display("FAIL vpace_idle_150: got %0d want 0", hif.v_state); end
    go_to(245);
    e_sa = '{100, 200};
    n_cmp++; if (sv_rise.size() != 1) begin n_err++; $display("FAIL vpace_sv_count: got %0d want 1", sv_rise.size()); end
    got = (sv_rise.size() > 0) ? sv_rise[0] : -1;
    n_cmp++; if (got != 240) begin n_err++; $display("FAIL vpace_sv_rise: got %0d want 240", got); end
    foreach (e_sa[i]) begin
      got = (i < sa_rise.size()) ? sa_rise[i] : -1;
      n_cmp++; if (got != e_sa[i]) begin n_err++; $display("FAIL vpace_sa_rise[%0d]: got %0d want %0d", i, got, e_sa[i]); end
    end
    n_cmp++; if (hif.beat_cnt !== 8'd2) begin n_err++; $display("FAIL vpace_beat_end: got %0d want 2", hif.beat_cnt); end
  endtask

  task automatic test_collisions();
    int e_sa[$], e_sv[$];
    int got;
    do_reset(1'b0);
    // pv edge at 150, inside the refractory period after the beat at 140.
    go_to(149); hif.pv = 1'b1;
    go_to(151); hif.pv = 1'b0;
    go_to(152);
    n_cmp++; if (hif.beat_cnt !== 8'd1) begin n_err++; $display("FAIL col_refr_beat: got %0d want 1", hif.beat_cnt); end
    go_to(170);
    n_cmp++; if (hif.v_state !== 2'd0) begin n_err++; $display("FAIL col_refr_no_restart: got %0d want 0", hif.v_state); end
    // pv edge on the AV terminal count at 240.
    go_to(239); hif.pv = 1'b1;
    go_to(240);
    n_cmp++; if (hif.sv !== 1'b0) begin n_err++; $display("FAIL col_av_no_sv: got %b want 0", hif.sv); end
    n_cmp++; if (hif.beat_cnt !== 8'd2) begin n_err++; $display("FAIL col_av_beat: got %0d want 2", hif.beat_cnt); end
    n_cmp++; if (hif.v_state !== 2'd2) begin n_err++; $display("FAIL col_av_refr: got %0d want 2", hif.v_state); end
    go_to(241); hif.pv = 1'b0;
    // pa edge on the intrinsic atrial count at 300: paced, still conducted.
    go_to(299); hif.pa = 1'b1;
    go_to(300);
    n_cmp++; if (hif.sa !== 1'b0) begin n_err++; $display("FAIL col_atc_no_sa: got %b want 0", hif.sa); end
    n_cmp++; if (hif.v_state !== 2'd1) begin n_err++; $display("FAIL col_atc_cond: got %0d want 1", hif.v_state); end
    go_to(301); hif.pa = 1'b0;
    go_to(405);
    e_sa = '{100, 200, 400};
    e_sv = '{140, 340};
    n_cmp++; if (sa_rise.size() != 3) begin n_err++; $display("FAIL col_sa_count: got %0d want 3", sa_rise.size()); end
    n_cmp++; if (sv_rise.size() != 2) begin n_err++; $display("FAIL col_sv_count: got %0d want 2", sv_rise.size()); end
    foreach (e_sa[i]) begin
      got = (i < sa_rise.size()) ? sa_rise[i] : -1;
      n_cmp++; if (got != e_sa[i]) begin n_err++; $display("FAIL col_sa_rise[%0d]: got %0d want %0d", i, got, e_sa[i]); end
    end
    foreach (e_sv[i]) begin
      got = (i < sv_rise.size()) ? sv_rise[i] : -1;
      n_cmp++; if (got != e_sv[i]) begin n_err++; $display("FAIL col_sv_rise[%0d]: got %0d want %0d", i, got, e_sv[i]); end
    end
    n_cmp++; if (hif.beat_cnt !== 8'd3) begin n_err++; $display("FAIL col_beat_end: got %0d want 3", hif.beat_cnt); end
  endtask

  task automatic test_escape_collision();
    int got;
    // Escape beat at 150 (blocked), then a paced atrium at 260 whose AV
    // terminal count lands on the next escape count at 300.
    do_reset(1'b1);
    go_to(201); hif.av_block = 1'b0;
    go_to(259); hif.pa = 1'b1;
    go_to(260);
    n_cmp++; if (hif.v_state !== 2'd1) begin n_err++; $display("FAIL esc_cond_260: got %0d want 1", hif.v_state); end
    go_to(261); hif.pa = 1'b0;
    go_to(299);
    n_cmp++; if (hif.beat_cnt !== 8'd1) begin n_err++; $display("FAIL esc_beat_299: got %0d want 1", hif.beat_cnt); end
    go_to(300);
    n_cmp++; if (hif.beat_cnt !== 8'd2) begin n_err++; $display("FAIL esc_beat_300: got %0d want 2", hif.beat_cnt); end
    n_cmp++; if (hif.sv !== 1'b1) begin n_err++; $display("FAIL esc_sv_300: got %b want 1", hif.sv); end
    n_cmp++; if (hif.v_state !== 2'd2) begin n_err++; $display("FAIL esc_refr_300: got %0d want 2", hif.v_state); end
    go_to(305);
    n_cmp++; if (sv_rise.size() != 2) begin n_err++; $display("FAIL esc_sv_count: got %0d want 2", sv_rise.size()); end
    got = (sv_rise.size() > 1) ? sv_rise[1] : -1;
    n_cmp++; if (got != 300) begin n_err++; $display("FAIL esc_sv_rise: got %0d want 300", got); end
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset(1'b0);
    go_to(141);
    n_cmp++; if (hif.sv !== 1'b1) begin n_err++; $display("FAIL rmid_sv_before: got %b want 1", hif.sv); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (hif.sv !== 1'b0) begin n_err++; $display("FAIL rmid_sv_async: got %b want 0", hif.sv); end
    n_cmp++; if (hif.sa !== 1'b0) begin n_err++; $display("FAIL rmid_sa_async: got %b want 0", hif.sa); end
    n_cmp++; if (hif.v_state !== 2'd0) begin n_err++; $display("FAIL rmid_v_state_async: got %0d want 0", hif.v_state); end
    n_cmp++; if (hif.beat_cnt !== 8'd0) begin n_err++; $display("FAIL rmid_beat_async: got %0d want 0", hif.beat_cnt); end
    repeat (2) @(posedge clk);
    clear_logs();
    @(negedge clk);
    rst = 1'b1;
    go_to(99);
    n_cmp++; if (hif.sa !== 1'b0) begin n_err++; $display("FAIL rmid_sa_99: got %b want 0", hif.sa); end
    go_to(105);
    n_cmp++; if (sa_rise.size() != 1) begin n_err++; $display("FAIL rmid_sa_count: got %0d want 1", sa_rise.size()); end
    got = (sa_rise.size() > 0) ? sa_rise[0] : -1;
    n_cmp++; if (got != 100) begin n_err++; $display("FAIL rmid_sa_rise: got %0d want 100", got); end
    n_cmp++; if (hif.v_state !== 2'd1) begin n_err++; $display("FAIL rmid_cond_105: got %0d want 1", hif.v_state); end
    n_cmp++; if (hif.beat_cnt !== 8'd0) begin n_err++; $display("FAIL rmid_beat_105: got %0d want 0", hif.beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_av_block();
    test_atrial_pace();
    test_vent_pace();
    test_collisions();
    test_escape_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
